// File: rtl/uart_move_decoder.sv
// uart_move_decoder: 8N1 UART receiver turning key presses into 2048 moves.
// Define ARROW_KEYS_EN to also decode ANSI arrow-key escape sequences.
module uart_move_decoder #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RsRx,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       newgame,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bitcnt;
    logic [7:0]             shreg;
    logic                   stop_hit;

    logic [7:0] lc;
    logic       w_move;
    logic       w_new;
    logic [1:0] w_dir;
    logic       dec_move;
    logic       dec_new;
    logic [1:0] dec_dir;

    // Flops preset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], RsRx};
    end

    assign rx_s     = sync[SYNC_STAGES-1];
    assign stop_hit = (state == STOP) && (cnt == BIT_LAST);
    assign rx_busy  = (state == START) || (state == DATA) || (state == STOP);

    always_comb begin
        lc     = shreg;
        w_move = 1'b0;
        w_new  = 1'b0;
        w_dir  = 2'b00;
        if (shreg >= 8'h41 && shreg <= 8'h5A) lc = shreg | 8'h20;
        unique case (1'b1)
            (lc == 8'h77): begin w_move = 1'b1; w_dir = 2'b00; end
            (lc == 8'h61): begin w_move = 1'b1; w_dir = 2'b01; end
            (lc == 8'h73): begin w_move = 1'b1; w_dir = 2'b10; end
            (lc == 8'h64): begin w_move = 1'b1; w_dir = 2'b11; end
            (lc == 8'h72): w_new = 1'b1;
            default: ;
        endcase
    end

`ifdef ARROW_KEYS_EN
    localparam logic [1:0] ESC_NONE    = 2'd0;
    localparam logic [1:0] GOT_ESC     = 2'd1;
    localparam logic [1:0] GOT_BRACKET = 2'd2;

    logic [1:0] esc;
    logic [1:0] esc_nxt;

    always_comb begin
        esc_nxt  = ESC_NONE;
        dec_move = 1'b0;
        dec_new  = 1'b0;
        dec_dir  = 2'b00;
        case (esc)
            GOT_ESC: begin
                if (shreg == 8'h5B) esc_nxt = GOT_BRACKET;
            end
            GOT_BRACKET: begin
                unique case (1'b1)
                    (shreg == 8'h41): begin dec_move = 1'b1; dec_dir = 2'b00; end
                    (shreg == 8'h42): begin dec_move = 1'b1; dec_dir = 2'b10; end
                    (shreg == 8'h43): begin dec_move = 1'b1; dec_dir = 2'b11; end
                    (shreg == 8'h44): begin dec_move = 1'b1; dec_dir = 2'b01; end
                    default: ;
                endcase
            end
            default: begin
                if (shreg == 8'h1B) begin
                    esc_nxt = GOT_ESC;
                end else begin
                    dec_move = w_move;
                    dec_new  = w_new;
                    dec_dir  = w_dir;
                end
            end
        endcase
    end

    // Tracker only advances on a completed frame; a bad stop bit resets it.
    always_ff @(posedge clk) begin
        if (rst)           esc <= ESC_NONE;
        else if (stop_hit) esc <= rx_s ? esc_nxt : ESC_NONE;
    end
`else
    assign dec_move = w_move;
    assign dec_new  = w_new;
    assign dec_dir  = w_dir;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            move_valid <= 1'b0;
            move_dir   <= 2'b00;
            newgame    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            newgame    <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        bitcnt <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        shreg  <= {rx_s, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state      <= IDLE;
                            move_valid <= dec_move;
                            newgame    <= dec_new;
                            if (dec_move) move_dir <= dec_dir;
                        end else begin
                            state     <= WAIT_HIGH;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
